// File: rtl/icache_loader.sv
// rtl/icache_loader.sv - program-load controller and fetch sequencer for the instruction cache
// Loads a length-prefixed little-endian halfword stream into the icache, then releases the CPU.
module icache_loader #(
    parameter int DEPTH   = 1000,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              cache_write,
    output logic [ADDR_W-1:0] cache_windex,
    output logic [15:0]       cache_wdata,
    input  logic              cpu_fetch_en,
    input  logic [31:0]       cpu_index,
    output logic              cache_not_enable,
    output logic [31:0]       cache_index,
    output logic              busy,
    output logic              cpu_run,
    output logic              error
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, DONE, ERROR
    } state_t;

    state_t              state, state_n;
    logic [15:0]         len_q, len_n;
    logic [7:0]          lo_q, lo_n;
    logic [ADDR_W-1:0]   index_q, index_n;
    logic [ADDR_W-1:0]   windex_q, windex_n;
    logic [15:0]         wdata_q, wdata_n;
    logic [TIMER_W-1:0]  timer_q, timer_n;
    logic                xfer;
    logic [15:0]         len_full;

    assign xfer         = rx_valid & rx_ready;
    assign len_full     = {rx_data, len_q[7:0]};
    assign cache_windex = windex_q;
    assign cache_wdata  = wdata_q;

    // Loading and fetching never overlap: the cache is only enabled once a program is resident.
    assign cache_index      = cpu_index;
    assign cache_not_enable = ~(cpu_run & cpu_fetch_en);

    always_comb begin
        state_n  = state;
        len_n    = len_q;
        lo_n     = lo_q;
        index_n  = index_q;
        windex_n = windex_q;
        wdata_n  = wdata_q;
        timer_n  = timer_q;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_n = LEN_LO;
                    index_n = '0;
                    timer_n = '0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_n   = {len_q[15:8], rx_data};
                    state_n = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_n = len_full;
                    if (len_full == 16'd0)
                        state_n = DONE;
                    else if (len_full > 16'(DEPTH))
                        state_n = ERROR;
                    else
                        state_n = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    lo_n    = rx_data;
                    state_n = DATA_HI;
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    windex_n = index_q;
                    wdata_n  = {rx_data, lo_q};
                    state_n  = WRITE;
                end
            end
            WRITE: begin
                index_n = index_q + ADDR_W'(1);
                if (16'(index_q) + 16'd1 == len_q)
                    state_n = DONE;
                else
                    state_n = DATA_LO;
            end
            default: state_n = IDLE;
        endcase

        // A transfer in the same cycle as the timeout wins; the counter only runs while waiting on the host.
        if (rx_ready) begin
            if (xfer)
                timer_n = '0;
            else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                timer_n = '0;
                state_n = ERROR;
            end else
                timer_n = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            lo_q        <= '0;
            index_q     <= '0;
            windex_q    <= '0;
            wdata_q     <= '0;
            timer_q     <= '0;
            rx_ready    <= 1'b0;
            busy        <= 1'b0;
            cache_write <= 1'b0;
            cpu_run     <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            len_q       <= len_n;
            lo_q        <= lo_n;
            index_q     <= index_n;
            windex_q    <= windex_n;
            wdata_q     <= wdata_n;
            timer_q     <= timer_n;
            rx_ready    <= state_n inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI};
            busy        <= state_n inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE};
            cache_write <= (state_n == WRITE);
            cpu_run     <= (state_n == DONE);
            error       <= (state_n == ERROR);
        end
    end

endmodule
